// File: rtl/slice_carry_pipe.sv
// slice_carry_pipe: pipelined add/subtract whose carry chain is split into STAGES registered segments.
// Each stage adds one segment plus the previous stage's FCO; operands skew forward, low sums ride along.
module slice_carry_pipe #(
   parameter int    WIDTH  = 16,
   parameter int    STAGES = 2,
   parameter string GSR    = "ENABLED"
) (
   input  logic             CLK,
   input  logic             RSTN,
   input  logic             CE,
   input  logic             LSR,
   input  logic             VALID_I,
   input  logic             SUB,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             CI,
   output logic [WIDTH-1:0] S,
   output logic             CO,
   output logic             OVF,
   output logic             VALID_O
);
   localparam int NS      = (STAGES < 1) ? 1 : STAGES;
   localparam int SEG     = WIDTH / NS;
   localparam bit USE_RST = (GSR == "ENABLED");

   if (STAGES < 1 || STAGES > 8 || WIDTH % NS != 0) begin : g_bad_param
      $error("slice_carry_pipe: STAGES must be 1..8 and divide WIDTH");
   end

   logic             rst_n_eff;
   logic [WIDTH-1:0] b_inv;
   assign rst_n_eff = RSTN | ~USE_RST;
   assign b_inv     = SUB ? ~B : B;

   for (genvar k = 0; k < NS; k++) begin : g_stg
      localparam int LO = k * SEG;
      // acc holds finished sums below segment k and still-unused A bits above it
      logic [WIDTH-1:0]    acc_in, acc_nx, acc_q;
      logic [WIDTH-LO-1:0] b_all;
      logic [SEG-1:0]      a_seg, b_seg;
      logic [SEG:0]        seg_sum;
      logic                cin, vin, fco_q, vld_q;
      if (k == 0) begin : g_first
         assign acc_in = A;
         assign b_all  = b_inv;
         assign cin    = CI;
         assign vin    = VALID_I;
      end else begin : g_next
         assign acc_in = g_stg[k-1].acc_q;
         assign b_all  = g_stg[k-1].g_fwd.b_q;
         assign cin    = g_stg[k-1].fco_q;
         assign vin    = g_stg[k-1].vld_q;
      end
      assign a_seg   = acc_in[LO +: SEG];
      assign b_seg   = b_all[SEG-1:0];
      assign seg_sum = {1'b0, a_seg} + {1'b0, b_seg} + {{SEG{1'b0}}, cin};
      always_comb begin
         acc_nx            = acc_in;
         acc_nx[LO +: SEG] = seg_sum[SEG-1:0];
      end
      always_ff @(posedge CLK or negedge rst_n_eff)
         if (!rst_n_eff) {acc_q, fco_q, vld_q} <= '0;
         else if (LSR) {acc_q, fco_q, vld_q} <= '0;
         else if (CE) {acc_q, fco_q, vld_q} <= {acc_nx, seg_sum[SEG], vin};
      if (k < NS - 1) begin : g_fwd
         logic [WIDTH-LO-SEG-1:0] b_q;
         always_ff @(posedge CLK or negedge rst_n_eff)
            if (!rst_n_eff) b_q <= '0;
            else if (LSR) b_q <= '0;
            else if (CE) b_q <= b_all[WIDTH-LO-1:SEG];
      end
      if (k == NS - 1) begin : g_last
         logic ovf_q;
         // carry into the MSB is recovered as a ^ b ^ sum at that bit
         always_ff @(posedge CLK or negedge rst_n_eff)
            if (!rst_n_eff) ovf_q <= 1'b0;
            else if (LSR) ovf_q <= 1'b0;
            else if (CE) ovf_q <= a_seg[SEG-1] ^ b_seg[SEG-1] ^ seg_sum[SEG-1] ^ seg_sum[SEG];
      end
   end

   assign S       = g_stg[NS-1].acc_q;
   assign CO      = g_stg[NS-1].fco_q;
   assign VALID_O = g_stg[NS-1].vld_q;
   assign OVF     = g_stg[NS-1].g_last.ovf_q;
endmodule

// File: tb/tb_slice_carry_pipe.sv
// tb_slice_carry_pipe: randomized and directed checks of slice_carry_pipe (WIDTH=16, STAGES=2)
// against a result-level delay-line model; a second instance covers GSR="DISABLED".
module tb_slice_carry_pipe;
   localparam int W = 16;
   typedef struct packed { logic v; logic [W-1:0] s; logic co; logic ovf; } res_t;

   logic clk = 0, rst_n = 1, ce = 0, lsr = 0, valid_i = 0, sub = 0, ci = 0;
   logic [W-1:0] a = '0, b = '0, s, s2;
   logic co, ovf, valid_o, co2, ovf2, valid_o2;
   res_t got, got2;
   res_t p [2];
   res_t p2 [2];
   int total = 0, bad = 0;

   assign got  = {valid_o, s, co, ovf};
   assign got2 = {valid_o2, s2, co2, ovf2};

   slice_carry_pipe #(.WIDTH(W), .STAGES(2), .GSR("ENABLED")) dut (
      .CLK(clk), .RSTN(rst_n), .CE(ce), .LSR(lsr), .VALID_I(valid_i), .SUB(sub),
      .A(a), .B(b), .CI(ci), .S(s), .CO(co), .OVF(ovf), .VALID_O(valid_o));

   slice_carry_pipe #(.WIDTH(W), .STAGES(2), .GSR("DISABLED")) dut2 (
      .CLK(clk), .RSTN(rst_n), .CE(ce), .LSR(lsr), .VALID_I(valid_i), .SUB(sub),
      .A(a), .B(b), .CI(ci), .S(s2), .CO(co2), .OVF(ovf2), .VALID_O(valid_o2));

   always #5 clk = ~clk;

   // Whole-word arithmetic: signed overflow when operands agree in sign and the sum does not.
   function automatic res_t calc(logic [W-1:0] x, logic [W-1:0] y, logic sb, logic c, logic v);
      logic [W-1:0] yy;
      logic [W:0] full;
      yy   = sb ? ~y : y;
      full = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, c};
      return {v, full[W-1:0], full[W], (x[W-1] == yy[W-1]) && (full[W-1] != x[W-1])};
   endfunction

   task automatic cyc();
      @(posedge clk);
      if (!rst_n || lsr) begin p[0] = '0; p[1] = '0; end
      else if (ce) begin p[1] = p[0]; p[0] = calc(a, b, sub, ci, valid_i); end
      if (lsr) begin p2[0] = '0; p2[1] = '0; end
      else if (ce) begin p2[1] = p2[0]; p2[0] = calc(a, b, sub, ci, valid_i); end
      #1;
   endtask

   task automatic rand_word(logic v);
      a = W'($urandom); b = W'($urandom); sub = 1'($urandom); ci = 1'($urandom); valid_i = v;
   endtask

   task automatic test_reset();
      #1 rst_n = 0; p[0] = '0; p[1] = '0;
      #1 total++;
      if (got !== '0) begin bad++; $display("FAIL reset_async: got %h want 0", got); end
      lsr = 1; ce = 1; cyc(); lsr = 0;
      total++;
      if (got !== p[1]) begin bad++; $display("FAIL reset_held: got %h want %h", got, p[1]); end
      total++;
      if (got2 !== p2[1]) begin bad++; $display("FAIL lsr_init_gsr_off: got %h want %h", got2, p2[1]); end
      #2 rst_n = 1;
      cyc();
      total++;
      if (got !== p[1]) begin bad++; $display("FAIL reset_release: got %h want %h", got, p[1]); end
   endtask

   task automatic test_directed();
      logic [W-1:0] va [5] = '{16'h00FF, 16'h0000, 16'h0005, 16'h7FFF, 16'hFFFF};
      logic [W-1:0] vb [5] = '{16'h0001, 16'h0001, 16'h0003, 16'h0001, 16'h0001};
      logic [W-1:0] es [5] = '{16'h0100, 16'hFFFF, 16'h0002, 16'h8000, 16'h0000};
      logic vs [5]   = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      logic eco [5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      logic eovf [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 5; i++) begin
         a = va[i]; b = vb[i]; sub = vs[i]; ci = vs[i]; valid_i = 1;
         cyc();
         rand_word(0);
         total++;
         if (valid_o !== 1'b0) begin bad++; $display("FAIL directed_early[%0d]: valid_o %b want 0", i, valid_o); end
         cyc();
         total++;
         if (got !== {1'b1, es[i], eco[i], eovf[i]})
            begin bad++; $display("FAIL directed[%0d]: got %h want %h", i, got, {1'b1, es[i], eco[i], eovf[i]}); end
         cyc();
         total++;
         if (valid_o !== 1'b0) begin bad++; $display("FAIL directed_once[%0d]: valid_o %b want 0", i, valid_o); end
      end
   endtask

   task automatic test_back_to_back();
      res_t exp_q [$];
      int n_sent = 0, n_got = 0;
      logic took;
      for (int c = 0; c < 16; c++) begin
         ce = !(c >= 5 && c < 8);
         if (ce && n_sent < 8) begin
            rand_word(1);
            exp_q.push_back(calc(a, b, sub, ci, 1'b1));
            n_sent++;
         end else rand_word(ce ? 1'b0 : 1'($urandom));
         took = ce;
         cyc();
         total++;
         if (got !== p[1]) begin bad++; $display("FAIL stream_cycle[%0d]: got %h want %h", c, got, p[1]); end
         if (took && valid_o === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin bad++; $display("FAIL stream_extra: got %h want none", got); end
            else begin
               if (got !== exp_q[0]) begin bad++; $display("FAIL stream_order: got %h want %h", got, exp_q[0]); end
               void'(exp_q.pop_front());
            end
            n_got++;
         end
      end
      ce = 1;
      total++;
      if (n_got != 8) begin bad++; $display("FAIL stream_count: got %0d want 8", n_got); end
   endtask

   task automatic test_lsr();
      res_t e;
      rand_word(0); cyc(); cyc();
      rand_word(1); cyc();
      rand_word(1); cyc();
      ce = 0; lsr = 1; rand_word(1);
      cyc();
      lsr = 0; ce = 1;
      total++;
      if (got !== '0) begin bad++; $display("FAIL lsr_clear: got %h want 0", got); end
      for (int i = 0; i < 3; i++) begin
         rand_word(0);
         cyc();
         total++;
         if (valid_o !== 1'b0 || got !== p[1]) begin bad++; $display("FAIL lsr_flushed[%0d]: got %h want %h", i, got, p[1]); end
      end
      rand_word(1);
      e = calc(a, b, sub, ci, 1'b1);
      cyc();
      rand_word(0);
      cyc();
      total++;
      if (got !== e) begin bad++; $display("FAIL lsr_after: got %h want %h", got, e); end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 3; i++) begin
         rand_word(1);
         cyc();
      end
      total++;
      if (got2 !== p2[1]) begin bad++; $display("FAIL gsr_off_pre: got %h want %h", got2, p2[1]); end
      #2 rst_n = 0; p[0] = '0; p[1] = '0;
      #1 total++;
      if (got !== '0) begin bad++; $display("FAIL async_clear: got %h want 0", got); end
      total++;
      if (got2 !== p2[1]) begin bad++; $display("FAIL gsr_off_hold: got %h want %h", got2, p2[1]); end
      #1 rst_n = 1;
      for (int i = 0; i < 5; i++) begin
         rand_word(1'($urandom));
         cyc();
         total++;
         if (got !== p[1]) begin bad++; $display("FAIL after_rst[%0d]: got %h want %h", i, got, p[1]); end
         total++;
         if (got2 !== p2[1]) begin bad++; $display("FAIL gsr_off_cont[%0d]: got %h want %h", i, got2, p2[1]); end
      end
   endtask

   initial begin
      p[0] = '0; p[1] = '0; p2[0] = '0; p2[1] = '0;
      test_reset();
      test_directed();
      test_back_to_back();
      test_lsr();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/slice_carry_pipe.md
Name: slice_carry_pipe

Overview:
- Pipelined adder/subtractor built on the ECP5 slice carry-chain arithmetic: A + B + CI, or A + ~B + CI.
- The WIDTH-bit chain is broken into STAGES equal segments, with a register and a carried FCO between segments, the same way a long CCU2C chain is retimed across slice registers.
- Sits directly downstream of the slice carry models; it consumes operand/carry-in words and produces registered sum, carry-out and overflow for the next datapath stage.

Parameters:
- WIDTH, 16, operand/sum width in bits; must be a multiple of STAGES.
- STAGES, 2, number of carry segments = pipeline depth; legal range 1..8.
- GSR, "ENABLED", "ENABLED": RSTN clears all registers. "DISABLED": RSTN ignored, registers power up 0.

Ports:
- CLK  input  1  clock, rising edge.
- RSTN  input  1  asynchronous active-low reset.
- CE  input  1  clock enable for the whole pipeline; 0 = hold every register.
- LSR  input  1  synchronous clear, active high, takes priority over CE.
- VALID_I  input  1  operand word valid.
- SUB  input  1  0: A+B+CI; 1: A+~B+CI.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- CI  input  1  carry-in to segment 0; drive 1 with SUB=1 for a plain subtract.
- S  output  WIDTH  sum, all bits time-aligned.
- CO  output  1  carry out of MSB (for SUB=1, 1 = no borrow).
- OVF  output  1  two's-complement overflow = carry into MSB XOR CO.
- VALID_O  output  1  S/CO/OVF valid.

Behaviour:
- SEG = WIDTH/STAGES. Segment k covers bits [k*SEG +: SEG] and is computed in pipeline stage k (k = 0..STAGES-1).
- Stage 0 registers:
  - segment 0 sum and its carry-out (FCO0);
  - skewed copies of A, B (B already conditionally inverted by SUB) for segments 1..STAGES-1.
- Stage k (k ≥ 1):
  - adds its delayed operand segment plus the FCO registered from stage k-1;
  - registers the new FCO;
  - forwards the remaining operand segments.
- Lower-segment sums are de-skewed through delay registers so all of S appears in the same cycle as VALID_O.
- Latency exactly STAGES cycles when CE=1 every cycle. Throughput one word per cycle. No back-pressure.
- Valid bit travels with the data, one flag per stage. Data registers load regardless of VALID_I; only VALID_O qualifies the outputs.
- CE=0: every data, carry and valid register holds. Outputs stay stable and VALID_O keeps its value.
- LSR=1 at a rising edge, with any CE: all valid flags, sums, carries and skew registers clear to 0. LSR over CE.
- RSTN low (GSR="ENABLED"): immediately, asynchronously, S=0, CO=0, OVF=0, VALID_O=0, and all internal registers 0. Release is synchronous to the next CLK edge; the first word accepted after release appears STAGES cycles later.
- Reset or LSR mid-operation: in-flight words are discarded, never emitted partially.
- OVF is computed in the last stage from that stage's carry-in to bit WIDTH-1 and its carry-out. It is registered alongside CO.
- Wrap-around: the sum is modulo 2^WIDTH. The carry beyond the MSB appears only on CO.
- STAGES=1: single registered adder, latency 1.
- An illegal parameter combination (WIDTH % STAGES ≠ 0, or STAGES outside 1..8) raises an elaboration-time $error.
- X on SUB/CI with VALID_I=1 propagates as X into S/CO. No X-masking.

Test Plan:
- WIDTH=16, STAGES=2; A=0x00FF, B=0x0001, SUB=0, CI=0, VALID_I=1 for one cycle -> 2 cycles later VALID_O=1 for one cycle, S=0x0100, CO=0, OVF=0. The segment-boundary carry crosses stages.
- A=0x0000, B=0x0001, SUB=1, CI=1 -> S=0xFFFF, CO=0 (borrow), OVF=0. A=0x0005, B=0x0003, SUB=1, CI=1 -> S=0x0002, CO=1.
- A=0x7FFF, B=0x0001, SUB=0, CI=0 -> S=0x8000, OVF=1, CO=0. A=0xFFFF, B=0x0001 -> S=0x0000, CO=1, OVF=0.
- Back-to-back stream of 8 random words with CE=1; then CE=0 for 3 cycles mid-stream -> outputs frozen during the stall; all 8 results correct, in order, latency 2 counted on CE=1 cycles only.
- LSR=1 for one cycle with CE=0 while 2 words in flight -> next cycle VALID_O=0, S=0. Neither word ever appears. A new word issued after LSR returns 2 cycles later.
- RSTN pulsed low between clock edges mid-stream -> S/CO/OVF/VALID_O go 0 without a CLK edge. With GSR="DISABLED" the same pulse has no effect and the results continue.
